// File: rtl/fenv_pkg.sv
// Shared types and constants for the filter ADSR envelope generator.
// The optional velocity scaling is enabled with the FENV_VELOCITY_EN macro.
package fenv_pkg;

  localparam int unsigned DW     = 16;
  localparam int unsigned SUM_W  = 18;
  localparam int unsigned STEP_W = 17;
  localparam int unsigned VEL_W  = 8;

  localparam logic [DW-1:0] PEAK_LVL = 16'h7FFF;
  localparam logic [DW-1:0] OUT_MAX  = 16'h7FFF;
  localparam logic [DW-1:0] OUT_MIN  = 16'h8000;

  localparam logic signed [SUM_W-1:0] SAT_HI = 18'sh07FFF;
  localparam logic signed [SUM_W-1:0] SAT_LO = 18'sh38000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } fenv_state_t;

  // Clamp an 18-bit signed sum to the 16-bit signed cutoff range.
  function automatic logic [DW-1:0] sat16(input logic signed [SUM_W-1:0] x);
    if (x > SAT_HI) begin
      return OUT_MAX;
    end else if (x < SAT_LO) begin
      return OUT_MIN;
    end
    return x[DW-1:0];
  endfunction

endpackage

// File: rtl/fenv_mod_mac.sv
// Registered cutoff modulation: sat16(base_cutoff + (scaled_level * env_amount) >>> 15).
module fenv_mod_mac
  import fenv_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] scaled_level,
  input  logic [DW-1:0] env_amount,
  input  logic [DW-1:0] base_cutoff,
  output logic [DW-1:0] cutoff_out
);

  logic signed [31:0]      lvl_w;
  logic signed [31:0]      amt_w;
  logic signed [31:0]      prod;
  logic signed [SUM_W-1:0] mod_v;
  logic signed [SUM_W-1:0] sum_v;

  // Level is non-negative, amount is signed Q1.15.
  assign lvl_w = signed'({16'd0, scaled_level});
  assign amt_w = 32'(signed'(env_amount));
  assign prod  = lvl_w * amt_w;
  assign mod_v = 18'(prod >>> 15);
  assign sum_v = 18'(signed'(base_cutoff)) + mod_v;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cutoff_out <= '0;
    end else begin
      cutoff_out <= sat16(sum_v);
    end
  end

endmodule

// File: rtl/filter_env_gen.sv
// ADSR envelope stepped on sample_tick, driving a saturated filter cutoff.
// FENV_VELOCITY_EN adds a velocity port that scales the modulation depth.
module filter_env_gen
  import fenv_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sample_tick,
  input  logic             gate,
  input  logic [DW-1:0]    attack_rate,
  input  logic [DW-1:0]    decay_rate,
  input  logic [DW-1:0]    sustain_lvl,
  input  logic [DW-1:0]    release_rate,
  input  logic [DW-1:0]    base_cutoff,
  input  logic [DW-1:0]    env_amount,
`ifdef FENV_VELOCITY_EN
  input  logic [VEL_W-1:0] velocity,
`endif
  output logic [DW-1:0]    env_out,
  output logic [DW-1:0]    cutoff_out,
  output logic             env_active
);

  fenv_state_t              state_q, state_d, seg;
  logic [DW-1:0]            level_q, level_d;
  logic [DW-1:0]            sus_lvl;
  logic [DW-1:0]            scaled_level;
  logic [STEP_W-1:0]        att_sum;
  logic signed [STEP_W-1:0] dec_diff;
  logic signed [STEP_W-1:0] rel_diff;
  logic                     enter_attack;

  assign sus_lvl  = sustain_lvl[DW-1] ? '0 : sustain_lvl;
  assign att_sum  = {1'b0, level_q} + {1'b0, attack_rate};
  assign dec_diff = signed'({1'b0, level_q} - {1'b0, decay_rate});
  assign rel_diff = signed'({1'b0, level_q} - {1'b0, release_rate});

  // Gate priority picks the segment this tick steps in.
  always_comb begin
    seg = state_q;
    unique case (state_q)
      ST_IDLE, ST_RELEASE:            if (gate)  seg = ST_ATTACK;
      ST_ATTACK, ST_DECAY, ST_SUSTAIN: if (!gate) seg = ST_RELEASE;
      default:                        seg = ST_IDLE;
    endcase
  end

  assign enter_attack = sample_tick && (seg == ST_ATTACK) && (state_q != ST_ATTACK);

  // Segment stepping; a zero rate finishes its segment on the same tick.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (sample_tick) begin
      state_d = seg;
      unique case (seg)
        ST_ATTACK: begin
          if ((attack_rate == '0) || (att_sum >= 17'(PEAK_LVL))) begin
            level_d = PEAK_LVL;
            state_d = ST_DECAY;
          end else begin
            level_d = att_sum[DW-1:0];
          end
        end
        ST_DECAY: begin
          if ((decay_rate == '0) || (dec_diff <= signed'({1'b0, sus_lvl}))) begin
            level_d = sus_lvl;
            state_d = ST_SUSTAIN;
          end else begin
            level_d = dec_diff[DW-1:0];
          end
        end
        ST_SUSTAIN: level_d = sus_lvl;
        ST_RELEASE: begin
          if ((release_rate == '0) || (rel_diff <= 17'sd0)) begin
            level_d = '0;
            state_d = ST_IDLE;
          end else begin
            level_d = rel_diff[DW-1:0];
          end
        end
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

`ifdef FENV_VELOCITY_EN
  logic [VEL_W-1:0] vel_lat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vel_lat <= '0;
    end else if (enter_attack) begin
      vel_lat <= velocity;
    end
  end

  // Velocity 255 gives unity depth; 127 gives half.
  assign scaled_level = 16'((24'(level_q) * 24'({1'b0, vel_lat} + 9'd1)) >> 8);
`else
  logic unused_enter;
  assign unused_enter = enter_attack;
  assign scaled_level = level_q;
`endif

  assign env_out    = level_q;
  assign env_active = (state_q != ST_IDLE);

  fenv_mod_mac u_mac (
    .clk          (clk),
    .reset_n      (reset_n),
    .scaled_level (scaled_level),
    .env_amount   (env_amount),
    .base_cutoff  (base_cutoff),
    .cutoff_out   (cutoff_out)
  );

endmodule

// File: tb/tb_filter_env_gen.sv
// Randomized bench for filter_env_gen against an integer ADSR model, plus directed literal checks.
module tb_filter_env_gen;

  localparam int P_IDLE = 0, P_ATT = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;
  localparam int PEAK = 32767;

  typedef struct packed {
    logic [15:0] lvl;
    logic [2:0]  ph;
    logic [7:0]  vel;
  } mstate_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_tick;
  logic        gate;
  logic [15:0] attack_rate, decay_rate, sustain_lvl, release_rate;
  logic [15:0] base_cutoff, env_amount;
  logic [7:0]  velocity;
  logic [15:0] env_out, cutoff_out;
  logic        env_active;

  int checks = 0;
  int failures = 0;

  mstate_t     m;
  logic [15:0] m_cut;

  always #5 clk = ~clk;

  filter_env_gen dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_tick  (sample_tick),
    .gate         (gate),
    .attack_rate  (attack_rate),
    .decay_rate   (decay_rate),
    .sustain_lvl  (sustain_lvl),
    .release_rate (release_rate),
    .base_cutoff  (base_cutoff),
    .env_amount   (env_amount),
`ifdef FENV_VELOCITY_EN
    .velocity     (velocity),
`endif
    .env_out      (env_out),
    .cutoff_out   (cutoff_out),
    .env_active   (env_active)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Next envelope state for one tick, straight from the ADSR rules.
  function automatic mstate_t model_step(input mstate_t s);
    mstate_t n;
    int lvl, r, sus, ph;
    n   = s;
    lvl = int'(s.lvl);
    ph  = int'(s.ph);
    sus = sustain_lvl[15] ? 0 : int'(sustain_lvl);
    if (gate && (ph == P_IDLE || ph == P_REL)) begin
      ph = P_ATT;
      n.vel = velocity;
    end else if (!gate && (ph == P_ATT || ph == P_DEC || ph == P_SUS)) begin
      ph = P_REL;
    end
    case (ph)
      P_ATT: begin
        r = lvl + int'(attack_rate);
        if (attack_rate == 0 || r >= PEAK) begin lvl = PEAK; ph = P_DEC; end
        else lvl = r;
      end
      P_DEC: begin
        r = lvl - int'(decay_rate);
        if (decay_rate == 0 || r <= sus) begin lvl = sus; ph = P_SUS; end
        else lvl = r;
      end
      P_SUS: lvl = sus;
      P_REL: begin
        r = lvl - int'(release_rate);
        if (release_rate == 0 || r <= 0) begin lvl = 0; ph = P_IDLE; end
        else lvl = r;
      end
      default: ;
    endcase
    n.lvl = 16'(lvl);
    n.ph  = 3'(ph);
    return n;
  endfunction

  function automatic logic [15:0] model_cut(input mstate_t s);
    int sl, amt, md, sum;
    sl = int'(s.lvl);
`ifdef FENV_VELOCITY_EN
    sl = (sl * (int'(s.vel) + 1)) / 256;
`endif
    amt = int'($signed(env_amount));
    md  = (sl * amt) >>> 15;
    sum = int'($signed(base_cutoff)) + md;
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    return 16'(sum);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m     <= '0;
      m_cut <= '0;
    end else begin
      m_cut <= model_cut(m);
      if (sample_tick) m <= model_step(m);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("env_out", int'(env_out), int'(m.lvl));
    check("env_active", int'(env_active), int'(m.ph != 3'(P_IDLE)));
    check("cutoff_out", int'(cutoff_out), int'(m_cut));
  end

  task automatic do_tick();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  function automatic logic [15:0] rnd_rate();
    case ($urandom_range(3))
      0:       return 16'h0000;
      1:       return 16'($urandom);
      default: return 16'($urandom_range(16'h3000, 16'h0100));
    endcase
  endfunction

  initial begin
    reset_n = 1'b0; sample_tick = 1'b0; gate = 1'b0; velocity = 8'd255;
    attack_rate = 16'h1000; decay_rate = 16'h2000; sustain_lvl = 16'h4000;
    release_rate = 16'h1000; base_cutoff = 16'h0000; env_amount = 16'h7FFF;
    repeat (3) @(negedge clk);
    check("reset_env", int'(env_out), 0);
    check("reset_cut", int'(cutoff_out), 0);
    check("reset_active", int'(env_active), 0);
    reset_n = 1'b1;

    // Reset honoured mid-attack
    gate = 1'b1;
    repeat (4) do_tick();
    check("pre_reset_lvl", int'(env_out), 16'h4000);
    #2 reset_n = 1'b0;
    @(negedge clk);
    check("midrst_env", int'(env_out), 0);
    check("midrst_cut", int'(cutoff_out), 0);
    check("midrst_active", int'(env_active), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Attack ramp from IDLE
    for (int i = 1; i <= 7; i++) begin
      do_tick();
      check("attack_step", int'(env_out), i * 16'h1000);
    end
    do_tick();
    check("attack_peak", int'(env_out), 16'h7FFF);
    check("attack_active", int'(env_active), 1);

    // Cutoff saturation both directions
    base_cutoff = 16'h7000; env_amount = 16'h7FFF;
    repeat (2) @(negedge clk);
    check("sat_hi", int'(cutoff_out), 16'h7FFF);
    base_cutoff = 16'h8000; env_amount = 16'h8000;
    repeat (2) @(negedge clk);
    check("sat_lo", int'(cutoff_out), 16'h8000);
    base_cutoff = 16'h0000; env_amount = 16'h4000;

    // Decay into sustain, then live sustain change
    do_tick();
    check("decay_1", int'(env_out), 16'h5FFF);
    do_tick();
    check("decay_sus", int'(env_out), 16'h4000);
    sustain_lvl = 16'h3000;
    do_tick();
    check("sus_track", int'(env_out), 16'h3000);

    // Release, re-gate mid-release, then release to IDLE
    gate = 1'b0;
    do_tick();
    check("release_1", int'(env_out), 16'h2000);
    gate = 1'b1;
    do_tick();
    check("regate", int'(env_out), 16'h3000);
    gate = 1'b0;
    do_tick();
    check("release_2", int'(env_out), 16'h2000);
    do_tick();
    check("release_3", int'(env_out), 16'h1000);
    do_tick();
    check("release_0", int'(env_out), 0);
    check("idle_active", int'(env_active), 0);

    // Zero attack rate jumps to peak; negative sustain clamps to 0
    attack_rate = 16'h0000; sustain_lvl = 16'hC000; decay_rate = 16'h0000;
    gate = 1'b1;
    do_tick();
    check("attack_zero", int'(env_out), 16'h7FFF);
    do_tick();
    check("neg_sustain", int'(env_out), 0);
    check("neg_sus_active", int'(env_active), 1);
    gate = 1'b0;
    do_tick();

    // Randomized run
    for (int i = 0; i < 6000; i++) begin
      sample_tick = ($urandom_range(2) == 0);
      if ($urandom_range(15) == 0) gate = ~gate;
      if ($urandom_range(63) == 0) begin
        attack_rate = rnd_rate(); decay_rate = rnd_rate(); release_rate = rnd_rate();
      end
      if ($urandom_range(31) == 0) sustain_lvl = 16'($urandom);
      if ($urandom_range(7) == 0) begin
        base_cutoff = 16'($urandom); env_amount = 16'($urandom);
      end
      velocity = 8'($urandom);
      if ($urandom_range(799) == 0) begin
        #2 reset_n = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b1;
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
